// File: rtl/branch_unit.sv
// Branch-resolution unit: decodes BR/Bcc, keeps SZCV flags with forwarding, registers target and
// take decision, then holds flush for FLUSH_CYCLES unstalled cycles. Optional stats: BRANCH_STATS_EN.
module branch_unit #(
    parameter int unsigned PC_W         = 12,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            valid_in,
    input  logic [PC_W-1:0] pc,
    input  logic [15:0]     instr,
    input  logic [3:0]      szcv_in,
    input  logic            szcv_we,
    output logic [PC_W-1:0] jdest,
    output logic            jflag,
    output logic            flush,
    output logic            busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     br_count,
    output logic [15:0]     taken_count
`endif
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    localparam logic [4:0] OP_BR  = 5'b10100;
    localparam logic [4:0] OP_BCC = 5'b10111;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        szcv_q, szcv_d;
    logic [PC_W-1:0]   jdest_q, jdest_d;
    logic              jflag_q, jflag_d;
    logic              flush_q, flush_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        flags;
    logic              fs, fz, fc, fv;
    logic [4:0]        op;
    logic [2:0]        cc;
    logic              is_branch;
    logic              cond_true;
    logic              accept;
    logic [PC_W-1:0]   offset;
    logic [PC_W-1:0]   target;

    // Flags written this cycle are forwarded so a Bcc right behind the ALU op sees them.
    assign flags = szcv_we ? szcv_in : szcv_q;
    assign fs    = flags[3];
    assign fz    = flags[2];
    assign fc    = flags[1];
    assign fv    = flags[0];

    assign op = instr[15:11];
    assign cc = instr[10:8];

    always_comb begin
        is_branch = 1'b0;
        cond_true = 1'b0;
        if (op == OP_BR) begin
            is_branch = 1'b1;
            cond_true = 1'b1;
        end else if (op == OP_BCC) begin
            is_branch = 1'b1;
            case (cc)
                3'b000:  cond_true = fz;
                3'b001:  cond_true = fs ^ fv;
                3'b010:  cond_true = fz | (fs ^ fv);
                3'b011:  cond_true = !fz;
                3'b100:  cond_true = fc;
                3'b101:  cond_true = !fc;
                3'b110:  cond_true = !(fs ^ fv);
                default: cond_true = !fz && !(fs ^ fv);
            endcase
        end
    end

    assign offset = PC_W'($signed(instr[7:0]));
    assign target = pc + offset + PC_W'(1);

    assign accept = (state_q == IDLE) && valid_in && !stall && is_branch;

    always_comb begin
        state_d = state_q;
        szcv_d  = szcv_q;
        jdest_d = jdest_q;
        jflag_d = jflag_q;
        flush_d = flush_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            if (szcv_we) begin
                szcv_d = szcv_in;
            end
            case (state_q)
                IDLE: begin
                    jflag_d = 1'b0;
                    if (accept && cond_true) begin
                        jdest_d = target;
                        jflag_d = 1'b1;
                        flush_d = 1'b1;
                        cnt_d   = CNT_W'(FLUSH_CYCLES);
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    jflag_d = 1'b0;
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        flush_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    jflag_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            szcv_q  <= '0;
            jdest_q <= '0;
            jflag_q <= 1'b0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            szcv_q  <= szcv_d;
            jdest_q <= jdest_d;
            jflag_q <= jflag_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    assign jdest = jdest_q;
    assign jflag = jflag_q;
    assign flush = flush_q;
    assign busy  = (state_q == FLUSH);

`ifdef BRANCH_STATS_EN
    logic [15:0] br_cnt_q, br_cnt_d;
    logic [15:0] tk_cnt_q, tk_cnt_d;

    // accept already excludes stall, so the counters hold while stalled.
    always_comb begin
        br_cnt_d = br_cnt_q;
        tk_cnt_d = tk_cnt_q;
        if (accept) begin
            if (br_cnt_q != '1) begin
                br_cnt_d = br_cnt_q + 16'd1;
            end
            if (cond_true && (tk_cnt_q != '1)) begin
                tk_cnt_d = tk_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
        end
    end

    assign br_count    = br_cnt_q;
    assign taken_count = tk_cnt_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit (PC_W=12, FLUSH_CYCLES=2).
module tb_branch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        valid_in;
    logic [11:0] pc;
    logic [15:0] instr;
    logic [3:0]  szcv_in;
    logic        szcv_we;
    logic [11:0] jdest;
    logic        jflag;
    logic        flush;
    logic        busy;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_count;
    logic [15:0] taken_count;
`endif

    int checks;
    int failures;

    branch_unit #(
        .PC_W(12),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .valid_in(valid_in),
        .pc(pc),
        .instr(instr),
        .szcv_in(szcv_in),
        .szcv_we(szcv_we),
        .jdest(jdest),
        .jflag(jflag),
        .flush(flush),
        .busy(busy)
`ifdef BRANCH_STATS_EN
        ,
        .br_count(br_count),
        .taken_count(taken_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0;
        instr    = 16'h0000;
        szcv_we  = 1'b0;
        szcv_in  = 4'b0000;
    endtask

    task automatic write_flags(input logic [3:0] f);
        szcv_we = 1'b1;
        szcv_in = f;
        step();
        szcv_we = 1'b0;
        szcv_in = 4'b0000;
    endtask

    task automatic issue(input logic [11:0] a, input logic [15:0] w);
        pc       = a;
        instr    = w;
        valid_in = 1'b1;
        step();
        idle_inputs();
    endtask

    // {instr, flags, expect_taken}
    logic [20:0] vec [7];

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        stall    = 1'b0;
        pc       = 12'h000;
        idle_inputs();

        step();
        step();
        check("rst_jdest", 32'(jdest), 32'h000);
        check("rst_jflag", 32'(jflag), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        rst = 1'b0;
        step();

        // Unconditional, negative offset.
        issue(12'h010, 16'hA0FE);
        check("br_jflag",  32'(jflag), 32'd1);
        check("br_jdest",  32'(jdest), 32'h00F);
        check("br_flush0", 32'(flush), 32'd1);
        check("br_busy0",  32'(busy),  32'd1);
        step();
        check("br_jflag1", 32'(jflag), 32'd0);
        check("br_flush1", 32'(flush), 32'd1);
        check("br_busy1",  32'(busy),  32'd1);
        step();
        check("br_flush2", 32'(flush), 32'd0);
        check("br_busy2",  32'(busy),  32'd0);

        // BE taken with Z set, then not taken with Z clear.
        write_flags(4'b0100);
        issue(12'h010, 16'hB805);
        check("be_t_jflag", 32'(jflag), 32'd1);
        check("be_t_jdest", 32'(jdest), 32'h016);
        step();
        step();
        write_flags(4'b0000);
        issue(12'h010, 16'hB805);
        check("be_n_jflag", 32'(jflag), 32'd0);
        check("be_n_flush", 32'(flush), 32'd0);
        check("be_n_jdest", 32'(jdest), 32'h016);
        step();
        check("be_n_flush1", 32'(flush), 32'd0);

        // Target wrap-around.
        issue(12'hFFF, 16'hA002);
        check("wrap_jflag", 32'(jflag), 32'd1);
        check("wrap_jdest", 32'(jdest), 32'h002);
        step();
        step();

        // BNE taken only through forwarding of the same-cycle flag write.
        write_flags(4'b0100);
        pc       = 12'h020;
        instr    = 16'hBB01;
        valid_in = 1'b1;
        szcv_we  = 1'b1;
        szcv_in  = 4'b0000;
        step();
        idle_inputs();
        check("bne_fwd_jflag", 32'(jflag), 32'd1);
        check("bne_fwd_jdest", 32'(jdest), 32'h022);
        step();
        step();

        // BGT with stored flags 0000 -> taken.
        issue(12'h030, 16'hBF03);
        check("bgt_t_jflag", 32'(jflag), 32'd1);
        check("bgt_t_jdest", 32'(jdest), 32'h034);
        step();
        step();

        // BGT with S=1 via forwarding -> not taken.
        pc       = 12'h030;
        instr    = 16'hBF03;
        valid_in = 1'b1;
        szcv_we  = 1'b1;
        szcv_in  = 4'b1000;
        step();
        idle_inputs();
        check("bgt_n_jflag", 32'(jflag), 32'd0);
        check("bgt_n_busy",  32'(busy),  32'd0);
        check("bgt_n_jdest", 32'(jdest), 32'h034);

        // Remaining condition codes and a non-branch opcode, flags forwarded.
        vec[0] = {16'hBC00, 4'b0010, 1'b1};  // C
        vec[1] = {16'hBD00, 4'b0010, 1'b0};  // !C
        vec[2] = {16'hB900, 4'b0001, 1'b1};  // S^V
        vec[3] = {16'hBA00, 4'b0000, 1'b0};  // Z|(S^V)
        vec[4] = {16'hBE00, 4'b1001, 1'b1};  // !(S^V)
        vec[5] = {16'hA800, 4'b0000, 1'b0};  // op 10101: not a branch
        vec[6] = {16'hB800, 4'b1011, 1'b0};  // Z clear
        for (int i = 0; i < 7; i++) begin
            pc       = 12'h100;
            instr    = vec[i][20:5];
            szcv_in  = vec[i][4:1];
            szcv_we  = 1'b1;
            valid_in = 1'b1;
            step();
            idle_inputs();
            check($sformatf("cc_vec%0d_jflag", i), 32'(jflag), 32'(vec[i][0]));
            check($sformatf("cc_vec%0d_busy", i),  32'(busy),  32'(vec[i][0]));
            if (vec[i][0]) begin
                check($sformatf("cc_vec%0d_jdest", i), 32'(jdest), 32'h101);
                step();
                step();
            end
        end

        // Stall during FLUSH, plus a second branch offered while busy.
        issue(12'h040, 16'hA003);
        check("stl_jflag0", 32'(jflag), 32'd1);
        check("stl_jdest",  32'(jdest), 32'h044);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stl_hold%0d_jflag", i), 32'(jflag), 32'd1);
            check($sformatf("stl_hold%0d_flush", i), 32'(flush), 32'd1);
            check($sformatf("stl_hold%0d_busy", i),  32'(busy),  32'd1);
        end
        stall    = 1'b0;
        pc       = 12'h050;
        instr    = 16'hA003;
        valid_in = 1'b1;
        step();
        check("stl_rel_jflag", 32'(jflag), 32'd0);
        check("stl_rel_flush", 32'(flush), 32'd1);
        check("stl_rel_busy",  32'(busy),  32'd1);
        step();
        idle_inputs();
        check("stl_end_jflag", 32'(jflag), 32'd0);
        check("stl_end_flush", 32'(flush), 32'd0);
        check("stl_end_busy",  32'(busy),  32'd0);
        check("stl_end_jdest", 32'(jdest), 32'h044);
        step();
        check("stl_squash_jflag", 32'(jflag), 32'd0);

        // Reset in the middle of FLUSH.
        issue(12'h060, 16'hA010);
        check("rmid_jflag", 32'(jflag), 32'd1);
        rst = 1'b1;
        step();
        check("rmid_jdest", 32'(jdest), 32'h000);
        check("rmid_jflag0", 32'(jflag), 32'd0);
        check("rmid_flush", 32'(flush), 32'd0);
        check("rmid_busy",  32'(busy),  32'd0);
`ifdef BRANCH_STATS_EN
        check("rmid_brcnt", 32'(br_count),    32'd0);
        check("rmid_tkcnt", 32'(taken_count), 32'd0);
`endif
        rst = 1'b0;
        step();

        // Three branches, two taken.
        issue(12'h010, 16'hA0FE);
        check("st_b1_jflag", 32'(jflag), 32'd1);
        step();
        step();
        issue(12'h010, 16'hB805);
        check("st_b2_jflag", 32'(jflag), 32'd0);
        issue(12'hFFF, 16'hA002);
        check("st_b3_jflag", 32'(jflag), 32'd1);
        check("st_b3_jdest", 32'(jdest), 32'h002);
        step();
        step();
`ifdef BRANCH_STATS_EN
        check("st_brcnt", 32'(br_count),    32'd3);
        check("st_tkcnt", 32'(taken_count), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
